// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the 256x8 latched-MAR RAM between the CPU port and the
// loader/front-panel port. It turns a req/ack handshake into the RAM's
// MAR-set / strobe / release sequence. All outputs are registered.
module ram_arbiter #(
  parameter int LDR_PRIORITY  = 0,  // 0 = round-robin, 1 = loader wins contention
  parameter int ACCESS_CYCLES = 1   // strobe width in cycles, 1..15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cpu_req,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata,
  input  logic       ldr_req,
  input  logic       ldr_wr,
  input  logic [7:0] ldr_addr,
  input  logic [7:0] ldr_wdata,
  output logic       ldr_ack,
  output logic [7:0] ldr_rdata,
  output logic [7:0] ram_bas,
  output logic       ram_wsa,
  output logic [7:0] ram_bis,
  output logic       ram_ws,
  output logic       ram_we,
  input  logic [7:0] ram_bos,
  output logic       busy,
  output logic       grant_ldr
);

  typedef enum logic [1:0] {IDLE, ADDR, ACC, REL} state_e;

  // transaction fields frozen at grant
  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
  } xact_t;

  state_e     state_q, state_d;
  xact_t      txn_q, txn_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_ldr_q, last_ldr_d;
  logic       grant_ldr_q, grant_ldr_d;
  logic       cpu_ack_q, cpu_ack_d;
  logic       ldr_ack_q, ldr_ack_d;
  logic [7:0] cpu_rdata_q, cpu_rdata_d;
  logic [7:0] ldr_rdata_q, ldr_rdata_d;
  logic [7:0] ram_bas_q, ram_bas_d;
  logic [7:0] ram_bis_q, ram_bis_d;
  logic       ram_wsa_q, ram_wsa_d;
  logic       ram_ws_q, ram_ws_d;
  logic       ram_we_q, ram_we_d;
  logic       busy_q, busy_d;
  logic       pick_ldr;

  // winner selection when leaving IDLE
  always_comb begin
    pick_ldr = 1'b0;
    if (ldr_req && !cpu_req)      pick_ldr = 1'b1;
    else if (cpu_req && !ldr_req) pick_ldr = 1'b0;
    else if (LDR_PRIORITY != 0)   pick_ldr = 1'b1;
    else                          pick_ldr = !last_ldr_q;
  end

  // next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    txn_d       = txn_q;
    cnt_d       = cnt_q;
    last_ldr_d  = last_ldr_q;
    grant_ldr_d = grant_ldr_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    ram_bas_d   = ram_bas_q;
    ram_bis_d   = ram_bis_q;
    cpu_ack_d   = 1'b0;
    ldr_ack_d   = 1'b0;
    ram_wsa_d   = 1'b0;
    ram_ws_d    = 1'b0;
    ram_we_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req || ldr_req) begin
          txn_d       = pick_ldr ? '{wr: ldr_wr, addr: ldr_addr, wdata: ldr_wdata}
                                 : '{wr: cpu_wr, addr: cpu_addr, wdata: cpu_wdata};
          last_ldr_d  = pick_ldr;
          grant_ldr_d = pick_ldr;
          // bas/bis are loaded here so they are stable from ADDR through REL
          ram_bas_d   = txn_d.addr;
          ram_bis_d   = txn_d.wdata;
          ram_wsa_d   = 1'b1;
          state_d     = ADDR;
        end
      end
      ADDR: begin
        cnt_d    = 4'(ACCESS_CYCLES - 1);
        ram_ws_d = txn_q.wr;
        ram_we_d = !txn_q.wr;
        state_d  = ACC;
      end
      ACC: begin
        if (cnt_q == 4'd0) begin
          // final strobe edge: capture read data and raise the winner's ack
          if (!txn_q.wr) begin
            if (grant_ldr_q) ldr_rdata_d = ram_bos;
            else             cpu_rdata_d = ram_bos;
          end
          ldr_ack_d = grant_ldr_q;
          cpu_ack_d = !grant_ldr_q;
          state_d   = REL;
        end else begin
          cnt_d    = cnt_q - 4'd1;
          ram_ws_d = txn_q.wr;
          ram_we_d = !txn_q.wr;
        end
      end
      REL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // state and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      txn_q       <= '0;
      cnt_q       <= '0;
      last_ldr_q  <= 1'b1;  // CPU wins the first contention
      grant_ldr_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
      ram_bas_q   <= '0;
      ram_bis_q   <= '0;
      ram_wsa_q   <= 1'b0;
      ram_ws_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      txn_q       <= txn_d;
      cnt_q       <= cnt_d;
      last_ldr_q  <= last_ldr_d;
      grant_ldr_q <= grant_ldr_d;
      cpu_ack_q   <= cpu_ack_d;
      ldr_ack_q   <= ldr_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
      ram_bas_q   <= ram_bas_d;
      ram_bis_q   <= ram_bis_d;
      ram_wsa_q   <= ram_wsa_d;
      ram_ws_q    <= ram_ws_d;
      ram_we_q    <= ram_we_d;
      busy_q      <= busy_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign ldr_ack   = ldr_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;
  assign ram_bas   = ram_bas_q;
  assign ram_bis   = ram_bis_q;
  assign ram_wsa   = ram_wsa_q;
  assign ram_ws    = ram_ws_q;
  assign ram_we    = ram_we_q;
  assign busy      = busy_q;
  assign grant_ldr = grant_ldr_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: three instances (round-robin AC=1, loader-priority
// AC=1, round-robin AC=3), each with its own latched-MAR RAM model.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  logic load;
  always #5 clk = ~clk;

  logic [2:0]       cpu_req, cpu_wr, ldr_req, ldr_wr;
  logic [2:0][7:0]  cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
  logic [2:0]       cpu_ack, ldr_ack, ram_wsa, ram_ws, ram_we, busy, grant_ldr;
  logic [2:0][7:0]  cpu_rdata, ldr_rdata, ram_bas, ram_bis, ram_bos;

  int total = 0;
  int bad   = 0;

  // default RAM image
  function automatic logic [7:0] img(input logic [7:0] a);
    case (a)
      8'h00:   img = 8'h20;
      8'h09:   img = 8'h81;
      default: img = a ^ 8'h3C;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [7:0] mem [256];
    logic [7:0] mar;
    int         inv_bad = 0;
    logic       pws = 1'b0;
    logic [7:0] pbas, pbis;

    ram_arbiter #(
      .LDR_PRIORITY (g == 1 ? 1 : 0),
      .ACCESS_CYCLES(g == 2 ? 3 : 1)
    ) dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_req(cpu_req[g]), .cpu_wr(cpu_wr[g]), .cpu_addr(cpu_addr[g]),
      .cpu_wdata(cpu_wdata[g]), .cpu_ack(cpu_ack[g]), .cpu_rdata(cpu_rdata[g]),
      .ldr_req(ldr_req[g]), .ldr_wr(ldr_wr[g]), .ldr_addr(ldr_addr[g]),
      .ldr_wdata(ldr_wdata[g]), .ldr_ack(ldr_ack[g]), .ldr_rdata(ldr_rdata[g]),
      .ram_bas(ram_bas[g]), .ram_wsa(ram_wsa[g]), .ram_bis(ram_bis[g]),
      .ram_ws(ram_ws[g]), .ram_we(ram_we[g]), .ram_bos(ram_bos[g]),
      .busy(busy[g]), .grant_ldr(grant_ldr[g])
    );

    // RAM model: MAR follows bas while wsa is high, write while ws is high
    always @(posedge clk) begin
      if (load) begin
        for (int i = 0; i < 256; i++) mem[i] <= img(8'(i));
      end else begin
        if (ram_wsa[g]) mar <= ram_bas[g];
        if (ram_ws[g])  mem[mar] <= ram_bis[g];
      end
    end
    assign ram_bos[g] = ram_we[g] ? mem[mar] : 8'h00;

    // strobe invariants, watched every cycle
    always @(negedge clk) begin
      if (ram_ws[g] && ram_we[g]) inv_bad++;
      if (ram_wsa[g] && (ram_ws[g] || ram_we[g])) inv_bad++;
      if (pws && ram_ws[g] && (ram_bas[g] != pbas || ram_bis[g] != pbis)) inv_bad++;
      pws  = ram_ws[g];
      pbas = ram_bas[g];
      pbis = ram_bis[g];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // one transaction on instance i; ack expected in cycle 3 after grant
  task automatic xact(input int i, input bit ldr, input bit wr,
                      input logic [7:0] a, input logic [7:0] d, input string tag);
    int lat = 0;
    bit got = 1'b0;
    if (ldr) begin
      ldr_wr[i] = wr; ldr_addr[i] = a; ldr_wdata[i] = d; ldr_req[i] = 1'b1;
    end else begin
      cpu_wr[i] = wr; cpu_addr[i] = a; cpu_wdata[i] = d; cpu_req[i] = 1'b1;
    end
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      got = ldr ? ldr_ack[i] : cpu_ack[i];
    end
    ldr_req[i] = 1'b0;
    cpu_req[i] = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    @(negedge clk);
  endtask

  initial begin
    cpu_req = '0; cpu_wr = '0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = '0; ldr_wr = '0; ldr_addr = '0; ldr_wdata = '0;
    reset_n = 1'b0;
    load    = 1'b1;
    repeat (2) @(negedge clk);
    load    = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

    // reset state
    chk("rst_busy",   32'(busy), 0);
    chk("rst_acks",   32'({cpu_ack, ldr_ack}), 0);
    chk("rst_strobe", 32'({ram_wsa, ram_ws, ram_we}), 0);
    chk("rst_grant",  32'(grant_ldr), 0);
    chk("rst_rdata",  32'({cpu_rdata[0], ldr_rdata[0]}), 0);

    // CPU read of 0x00
    cpu_wr[0] = 1'b0; cpu_addr[0] = 8'h00; cpu_req[0] = 1'b1;
    @(negedge clk);  // cycle 1: ADDR
    chk("t1_addr_wsa",  32'(ram_wsa[0]), 1);
    chk("t1_addr_we",   32'(ram_we[0]), 0);
    chk("t1_busy",      32'(busy[0]), 1);
    chk("t1_grant",     32'(grant_ldr[0]), 0);
    @(negedge clk);  // cycle 2: ACC
    chk("t1_acc_wsa",   32'(ram_wsa[0]), 0);
    chk("t1_acc_we",    32'(ram_we[0]), 1);
    chk("t1_acc_ack",   32'(cpu_ack[0]), 0);
    @(negedge clk);  // cycle 3: REL
    chk("t1_ack",       32'(cpu_ack[0]), 1);
    chk("t1_rdata",     32'(cpu_rdata[0]), 32'h20);
    chk("t1_ldr_ack",   32'(ldr_ack[0]), 0);
    chk("t1_rel_we",    32'(ram_we[0]), 0);
    chk("t1_rel_wsa",   32'(ram_wsa[0]), 0);
    cpu_req[0] = 1'b0;
    @(negedge clk);  // cycle 4: IDLE
    chk("t1_idle_busy", 32'(busy[0]), 0);
    chk("t1_ack_pulse", 32'(cpu_ack[0]), 0);

    // loader write 0xA5 -> 0xFF, then CPU read of 0xFF
    ldr_wr[0] = 1'b1; ldr_addr[0] = 8'hFF; ldr_wdata[0] = 8'hA5; ldr_req[0] = 1'b1;
    @(negedge clk);
    chk("t2_grant",   32'(grant_ldr[0]), 1);
    chk("t2_addr_bis", 32'(ram_bis[0]), 32'hA5);
    chk("t2_addr_bas", 32'(ram_bas[0]), 32'hFF);
    chk("t2_addr_ws",  32'(ram_ws[0]), 0);
    @(negedge clk);
    chk("t2_acc_ws",   32'(ram_ws[0]), 1);
    chk("t2_acc_bis",  32'(ram_bis[0]), 32'hA5);
    @(negedge clk);
    chk("t2_rel_ws",   32'(ram_ws[0]), 0);
    chk("t2_rel_bis",  32'(ram_bis[0]), 32'hA5);
    chk("t2_ack",      32'(ldr_ack[0]), 1);
    ldr_req[0] = 1'b0;
    @(negedge clk);
    xact(0, 1'b0, 1'b0, 8'hFF, 8'h00, "t2_rd");
    chk("t2_cpu_rdata", 32'(cpu_rdata[0]), 32'hA5);
    chk("t2_ldr_rdata", 32'(ldr_rdata[0]), 32'h00);

    // round-robin under continuous contention: CPU, LDR, CPU, LDR
    do_reset();
    cpu_wr[0] = 1'b0; cpu_addr[0] = 8'h00; cpu_req[0] = 1'b1;
    ldr_wr[0] = 1'b0; ldr_addr[0] = 8'h09; ldr_req[0] = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      chk($sformatf("t3_cack_c%0d", c), 32'(cpu_ack[0]), 32'(c == 3 || c == 11));
      chk($sformatf("t3_lack_c%0d", c), 32'(ldr_ack[0]), 32'(c == 7 || c == 15));
      if (c % 4 == 1)
        chk($sformatf("t3_grant_c%0d", c), 32'(grant_ldr[0]), 32'(c == 5 || c == 13));
      if (c == 16) begin cpu_req[0] = 1'b0; ldr_req[0] = 1'b0; end
    end
    @(negedge clk);
    chk("t3_cpu_rdata", 32'(cpu_rdata[0]), 32'h20);
    chk("t3_ldr_rdata", 32'(ldr_rdata[0]), 32'h81);

    // loader priority: loader served while it holds req, then CPU
    cpu_wr[1] = 1'b0; cpu_addr[1] = 8'h00; cpu_req[1] = 1'b1;
    ldr_wr[1] = 1'b0; ldr_addr[1] = 8'h09; ldr_req[1] = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      chk($sformatf("t4_lack_c%0d", c), 32'(ldr_ack[1]), 32'(c == 3 || c == 7 || c == 11));
      chk($sformatf("t4_cack_c%0d", c), 32'(cpu_ack[1]), 32'(c == 15));
      if (c == 12) ldr_req[1] = 1'b0;
      if (c == 15) cpu_req[1] = 1'b0;
    end
    chk("t4_grant_last", 32'(grant_ldr[1]), 0);
    chk("t4_cpu_rdata",  32'(cpu_rdata[1]), 32'h20);
    chk("t4_ldr_rdata",  32'(ldr_rdata[1]), 32'h81);

    // ACCESS_CYCLES=3 loader read of 0x09
    ldr_wr[2] = 1'b0; ldr_addr[2] = 8'h09; ldr_req[2] = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk($sformatf("t5_we_c%0d", c),  32'(ram_we[2]), 32'(c >= 2 && c <= 4));
      chk($sformatf("t5_wsa_c%0d", c), 32'(ram_wsa[2]), 32'(c == 1));
      chk($sformatf("t5_ack_c%0d", c), 32'(ldr_ack[2]), 32'(c == 5));
      if (c == 5) ldr_req[2] = 1'b0;
    end
    chk("t5_ldr_rdata", 32'(ldr_rdata[2]), 32'h81);
    chk("t5_busy",      32'(busy[2]), 0);

    // reset during ACC of a CPU write
    cpu_wr[0] = 1'b1; cpu_addr[0] = 8'h10; cpu_wdata[0] = 8'h77; cpu_req[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_acc_ws", 32'(ram_ws[0]), 1);
    reset_n    = 1'b0;
    cpu_req[0] = 1'b0;
    @(negedge clk);
    chk("t6_ws",   32'(ram_ws[0]), 0);
    chk("t6_busy", 32'(busy[0]), 0);
    chk("t6_ack",  32'(cpu_ack[0]), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("t6_ack_after", 32'(cpu_ack[0]), 0);
    chk("t6_rdata_rst", 32'(cpu_rdata[0]), 0);
    xact(0, 1'b0, 1'b0, 8'h00, 8'h00, "t6_rd");
    chk("t6_rdata", 32'(cpu_rdata[0]), 32'h20);

    chk("inv_0", 32'(g_dut[0].inv_bad), 0);
    chk("inv_1", 32'(g_dut[1].inv_bad), 0);
    chk("inv_2", 32'(g_dut[2].inv_bad), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
